tristate_bus_arbiter: RTL and testbench
=======================================

// Module: tristate_bus_arbiter
//
// PURPOSE
// Round-robin arbiter that owns a shared tri-state bus built from three_state
// drivers. Drives the per-requester 'enable' inputs so at most one driver is
// active. Inserts a programmable all-high-Z turnaround gap between owners so
// drivers never overlap. Caps bus ownership time so no requester can starve others.
//
// PARAMETERS
// N_REQ     4   number of requesters/drivers on the bus (>=2)
// TURN_CYC  1   high-Z turnaround cycles between owners (>=1)
// MAX_HOLD  16  max consecutive OWN cycles per grant; 0 = unlimited
//
// PORTS
// clk        input   1                  rising-edge clock
// rst_n      input   1                  async reset, active low
// req        input   N_REQ              level request, one bit per requester
// en         output  N_REQ              tri-state enables, one-hot or zero
// gnt_valid  output  1                  1 while any en bit is high
// gnt_id     output  $clog2(N_REQ)      index of current owner (valid when gnt_valid)
// turn       output  1                  1 during turnaround cycles
//
// BEHAVIOUR
// - One clock; reset is asynchronous and active-low (rst_n).
// - All outputs are registered.
// - Reset values: state=IDLE, en=0, gnt_valid=0, gnt_id=0, turn=0, rr_ptr=0,
//   hold_cnt=0. On rst_n falling, en clears immediately with no clock edge.
// - States:
//   - IDLE: bus high-Z.
//     - At an edge with req!=0: pick the first set bit scanning rr_ptr, rr_ptr+1, ...
//       mod N_REQ. Go to OWN at that edge: en[k]=1, gnt_id=k, hold_cnt=1.
//     - Latency: req sampled high at edge t -> en high after edge t.
//   - OWN:
//     - en[k] stays high and hold_cnt increments each edge.
//     - Release at the first edge where req[k]==0, or where hold_cnt==MAX_HOLD
//       (MAX_HOLD!=0).
//     - On release: en=0, gnt_valid=0, turn=1, rr_ptr=(k+1) mod N_REQ, go to TURN.
//     - Requests from other requesters during OWN are ignored.
//   - TURN:
//     - en=0 for exactly TURN_CYC cycles.
//     - At the edge ending the last TURN cycle, arbitrate as in IDLE:
//       - req!=0 -> OWN directly (turn=0).
//       - else -> IDLE.
//     - A req pulse that rises and falls entirely within TURN is not remembered.
// - Invariants, checked by assertions:
//   - $onehot0(en) always.
//   - gnt_valid == |en.
//   - turn and gnt_valid are never both 1.
//   - Between en deasserting for owner A and asserting for any owner, at least
//     TURN_CYC all-zero cycles elapse. This includes re-granting A.
// - A requester forced off by MAX_HOLD that still requests gets the lowest
//   priority. If it is the only requester, it is re-granted after TURN.
// - Counter widths: hold_cnt is $clog2(MAX_HOLD+1) bits; it saturates and does
//   not wrap. The turn counter is $clog2(TURN_CYC+1) bits.
// - rr_ptr wraps from N_REQ-1 to 0. It advances only on release, never in IDLE.
// - X on req while in IDLE/TURN is an error; an assertion flags it.
//
// TESTING
// 1. Hold rst_n=0 for 3 edges with req=4'b1111 -> en=0, gnt_valid=0, turn=0,
//    gnt_id=0 throughout.
// 2. req=4'b0100 before edges 1..5, 0 before edge 6 -> en=0100 after edges 1..5;
//    en=0, turn=1 after edge 6; IDLE after edge 7.
// 3. req=4'b1111 constant, MAX_HOLD=16 -> owners 0,1,2,3,0 in order; each holds
//    16 cycles; exactly 1 zero-en cycle between owners.
// 4. rr_ptr=1 (after owner 0 released), req=4'b1001 -> grant goes to 3, then to 0.
// 5. rst_n driven low mid-OWN (en=0010), between clock edges -> en=0 within the
//    same cycle; after release, req=4'b0011 grants 0 (rr_ptr=0).
// 6. TURN_CYC=3, MAX_HOLD=4, req=4'b0001 held -> en[0] high 4 cycles, 0 for
//    3 cycles, repeating; turn high exactly during the 3 gap cycles.

Source files
------------

// File: rtl/tristate_bus_arbiter.sv
// rtl/tristate_bus_arbiter.sv - round-robin owner arbiter for a shared tri-state bus
//
// Grants one requester at a time the right to drive a shared three-state bus,
// inserts an all-high-Z turnaround gap between owners and caps ownership time.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous reset, active low
//   req        level request, one bit per requester
//   en         tri-state driver enables, one-hot or zero
//   gnt_valid  high while any en bit is high
//   gnt_id     index of the current owner (meaningful when gnt_valid)
//   turn       high during turnaround cycles
module tristate_bus_arbiter #(
  parameter int N_REQ    = 4,
  parameter int TURN_CYC = 1,
  parameter int MAX_HOLD = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req,
  output logic [N_REQ-1:0]         en,
  output logic                     gnt_valid,
  output logic [$clog2(N_REQ)-1:0] gnt_id,
  output logic                     turn
);

  localparam int IDW = $clog2(N_REQ);
  // Unlimited hold (MAX_HOLD == 0) still needs a 1-bit saturating counter.
  localparam int HCW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam int TCW = $clog2(TURN_CYC + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OWN  = 2'd1,
    S_TURN = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [N_REQ-1:0] en_nxt;
  logic             gnt_valid_nxt;
  logic [IDW-1:0]   gnt_id_nxt;
  logic             turn_nxt;
  logic [IDW-1:0]   rr_ptr, rr_ptr_nxt;
  logic [HCW-1:0]   hold_cnt, hold_cnt_nxt;
  logic [TCW-1:0]   turn_cnt, turn_cnt_nxt;

  logic             arb_found;
  logic [IDW-1:0]   arb_id;
  logic             hold_at_max;
  logic             do_arb;
  logic [IDW-1:0]   ptr_after_owner;

  // Rotating priority scan: first set request at rr_ptr, rr_ptr+1, ... mod N_REQ.
  always_comb begin
    int idx;
    arb_found = 1'b0;
    arb_id    = '0;
    idx       = 0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= N_REQ) begin
        idx = idx - N_REQ;
      end
      if (!arb_found && req[idx[IDW-1:0]]) begin
        arb_found = 1'b1;
        arb_id    = idx[IDW-1:0];
      end
    end
  end

  assign hold_at_max     = (MAX_HOLD != 0) && (hold_cnt == HCW'(MAX_HOLD));
  assign ptr_after_owner = (gnt_id == IDW'(N_REQ - 1)) ? '0 : gnt_id + 1'b1;

  always_comb begin
    state_nxt     = state;
    en_nxt        = en;
    gnt_valid_nxt = gnt_valid;
    gnt_id_nxt    = gnt_id;
    turn_nxt      = turn;
    rr_ptr_nxt    = rr_ptr;
    hold_cnt_nxt  = hold_cnt;
    turn_cnt_nxt  = turn_cnt;
    do_arb        = 1'b0;

    case (state)
      S_IDLE: begin
        do_arb = 1'b1;
      end
      S_OWN: begin
        // Only the owner's request matters here; others wait for arbitration.
        if (!req[gnt_id] || hold_at_max) begin
          state_nxt     = S_TURN;
          en_nxt        = '0;
          gnt_valid_nxt = 1'b0;
          turn_nxt      = 1'b1;
          turn_cnt_nxt  = TCW'(1);
          // Owner drops to lowest priority for the next scan.
          rr_ptr_nxt    = ptr_after_owner;
        end else if (hold_cnt != '1) begin
          hold_cnt_nxt = hold_cnt + 1'b1;
        end
      end
      S_TURN: begin
        if (turn_cnt == TCW'(TURN_CYC)) begin
          do_arb = 1'b1;
        end else begin
          turn_cnt_nxt = turn_cnt + 1'b1;
        end
      end
      default: begin
        state_nxt     = S_IDLE;
        en_nxt        = '0;
        gnt_valid_nxt = 1'b0;
        turn_nxt      = 1'b0;
      end
    endcase

    // Shared by IDLE and the last TURN cycle: grant straight into OWN or park in IDLE.
    if (do_arb) begin
      state_nxt     = S_IDLE;
      en_nxt        = '0;
      gnt_valid_nxt = 1'b0;
      turn_nxt      = 1'b0;
      if (arb_found) begin
        state_nxt      = S_OWN;
        en_nxt[arb_id] = 1'b1;
        gnt_valid_nxt  = 1'b1;
        gnt_id_nxt     = arb_id;
        hold_cnt_nxt   = HCW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      en        <= '0;
      gnt_valid <= 1'b0;
      gnt_id    <= '0;
      turn      <= 1'b0;
      rr_ptr    <= '0;
      hold_cnt  <= '0;
      turn_cnt  <= '0;
    end else begin
      state     <= state_nxt;
      en        <= en_nxt;
      gnt_valid <= gnt_valid_nxt;
      gnt_id    <= gnt_id_nxt;
      turn      <= turn_nxt;
      rr_ptr    <= rr_ptr_nxt;
      hold_cnt  <= hold_cnt_nxt;
      turn_cnt  <= turn_cnt_nxt;
    end
  end

  // Turnaround watchdog: counts all-zero en cycles (saturating at TURN_CYC)
  // so any new owner, including the previous one, can be checked for a full gap.
  logic [N_REQ-1:0] prev_en;
  logic [TCW-1:0]   zero_run;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_en  <= '0;
      zero_run <= TCW'(TURN_CYC);
    end else begin
      if (|en) begin
        if (prev_en == '0) begin
          a_gap_len : assert (zero_run == TCW'(TURN_CYC));
        end else begin
          a_no_swap : assert (en == prev_en);
        end
        zero_run <= '0;
      end else if (zero_run != TCW'(TURN_CYC)) begin
        zero_run <= zero_run + 1'b1;
      end
      prev_en <= en;
    end
  end

  a_onehot : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(en));
  a_gv_en  : assert property (@(posedge clk) disable iff (!rst_n) gnt_valid == (|en));
  a_excl   : assert property (@(posedge clk) disable iff (!rst_n) !(turn && gnt_valid));
  a_req_x  : assert property (@(posedge clk) disable iff (!rst_n)
                              (state != S_OWN) |-> !$isunknown(req));

endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// tb/tb_tristate_bus_arbiter.sv - scoreboard bench for tristate_bus_arbiter
module tb_tristate_bus_arbiter;

  localparam int S_IDLE = 0;
  localparam int S_OWN  = 1;
  localparam int S_TURN = 2;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n_a, rst_n_b;
  logic [3:0] req_a, req_b;
  logic [3:0] en_a, en_b;
  logic       gv_a, gv_b;
  logic [1:0] id_a, id_b;
  logic       turn_a, turn_b;

  tristate_bus_arbiter #(.N_REQ(4), .TURN_CYC(1), .MAX_HOLD(16)) dut_a (
    .clk(clk), .rst_n(rst_n_a), .req(req_a), .en(en_a),
    .gnt_valid(gv_a), .gnt_id(id_a), .turn(turn_a)
  );

  tristate_bus_arbiter #(.N_REQ(4), .TURN_CYC(3), .MAX_HOLD(4)) dut_b (
    .clk(clk), .rst_n(rst_n_b), .req(req_b), .en(en_b),
    .gnt_valid(gv_b), .gnt_id(id_b), .turn(turn_b)
  );

  typedef struct {
    int st;
    int owner;
    int hold;
    int gap;
    int ptr;
  } mdl_t;

  typedef struct {
    int         dut;
    logic [3:0] en;
    logic       gv;
    logic [1:0] id;
    logic       turn;
  } exp_t;

  mdl_t ma, mb;
  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic mdl_t mdl_reset();
    mdl_t m;
    m.st = S_IDLE; m.owner = 0; m.hold = 0; m.gap = 0; m.ptr = 0;
    return m;
  endfunction

  // Reference behaviour: state after one clock edge given the sampled request.
  function automatic mdl_t mdl_next(mdl_t m, logic [3:0] r, int tc, int mh);
    mdl_t n;
    bit   arb;
    bit   found;
    int   k;
    n     = m;
    arb   = 1'b0;
    found = 1'b0;
    if (m.st == S_IDLE) begin
      arb = 1'b1;
    end else if (m.st == S_TURN) begin
      if (m.gap == 1) arb = 1'b1;
      else n.gap = m.gap - 1;
    end else begin
      if (!r[m.owner[1:0]] || (mh != 0 && m.hold >= mh)) begin
        n.st  = S_TURN;
        n.gap = tc;
        n.ptr = (m.owner + 1) % 4;
      end else begin
        n.hold = m.hold + 1;
      end
    end
    if (arb) begin
      n.st = S_IDLE;
      for (int i = 0; i < 4; i++) begin
        k = (m.ptr + i) % 4;
        if (!found && r[k[1:0]]) begin
          found   = 1'b1;
          n.st    = S_OWN;
          n.owner = k;
          n.hold  = 1;
        end
      end
    end
    return n;
  endfunction

  function automatic exp_t mk_exp(int d, mdl_t m);
    exp_t e;
    e.dut  = d;
    e.gv   = (m.st == S_OWN);
    e.en   = e.gv ? (4'b0001 << m.owner) : 4'b0000;
    e.id   = m.owner[1:0];
    e.turn = (m.st == S_TURN);
    return e;
  endfunction

  // One clock: drive requests, predict, let the edge pass, then drain the scoreboard.
  task automatic cycle(input logic [3:0] ra, input logic [3:0] rb);
    exp_t e;
    @(negedge clk);
    req_a = ra;
    req_b = rb;
    ma = rst_n_a ? mdl_next(ma, ra, 1, 16) : mdl_reset();
    mb = rst_n_b ? mdl_next(mb, rb, 3, 4)  : mdl_reset();
    sb.push_back(mk_exp(0, ma));
    sb.push_back(mk_exp(1, mb));
    @(posedge clk);
    #1;
    while (sb.size() != 0) begin
      e = sb.pop_front();
      if (e.dut == 0) begin
        check("a_en", 32'(en_a), 32'(e.en));
        check("a_gnt_valid", 32'(gv_a), 32'(e.gv));
        check("a_turn", 32'(turn_a), 32'(e.turn));
        if (e.gv) check("a_gnt_id", 32'(id_a), 32'(e.id));
      end else begin
        check("b_en", 32'(en_b), 32'(e.en));
        check("b_gnt_valid", 32'(gv_b), 32'(e.gv));
        check("b_turn", 32'(turn_b), 32'(e.turn));
        if (e.gv) check("b_gnt_id", 32'(id_b), 32'(e.id));
      end
    end
  endtask

  task automatic reset_a();
    rst_n_a = 1'b0;
    ma = mdl_reset();
    cycle(4'b0000, 4'b0000);
    rst_n_a = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   run;
    int   gap;
    logic pgv;
    int   owners[$];
    int   runs[$];
    int   gaps[$];
    int   exp_own[5];

    rst_n_a = 1'b0;
    rst_n_b = 1'b0;
    req_a   = 4'b0000;
    req_b   = 4'b0000;
    ma      = mdl_reset();
    mb      = mdl_reset();

    // Reset held with all requests asserted.
    for (int i = 0; i < 3; i++) begin
      cycle(4'b1111, 4'b0000);
      check("t1_gnt_id", 32'(id_a), 32'd0);
    end
    rst_n_a = 1'b1;

    // Single requester, release, then back to idle.
    for (int i = 0; i < 5; i++) begin
      cycle(4'b0100, 4'b0000);
      check("t2_en", 32'(en_a), 32'h4);
    end
    cycle(4'b0000, 4'b0000);
    check("t2_rel_turn", 32'(turn_a), 32'd1);
    cycle(4'b0000, 4'b0000);
    check("t2_idle_turn", 32'(turn_a), 32'd0);
    check("t2_idle_gv", 32'(gv_a), 32'd0);

    // All requesting: rotation 0,1,2,3,0 with 16-cycle holds and one-cycle gaps.
    reset_a();
    run = 0; gap = 0; pgv = 1'b0;
    for (int c = 0; c < 90; c++) begin
      cycle(4'b1111, 4'b0000);
      if (gv_a) begin
        if (!pgv) begin
          if (owners.size() != 0) gaps.push_back(gap);
          owners.push_back(int'(id_a));
        end
        run++;
        gap = 0;
      end else begin
        if (pgv) runs.push_back(run);
        run = 0;
        gap++;
      end
      pgv = gv_a;
    end
    exp_own = '{0, 1, 2, 3, 0};
    for (int i = 0; i < 5; i++)
      check($sformatf("t3_owner%0d", i), (i < owners.size()) ? owners[i] : -1, exp_own[i]);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t3_hold%0d", i), (i < runs.size()) ? runs[i] : -1, 16);
      check($sformatf("t3_gap%0d", i), (i < gaps.size()) ? gaps[i] : -1, 1);
    end
    for (int i = 0; i < 20; i++) cycle(4'b0000, 4'b0000);

    // Pointer at 1 after owner 0 releases: 4'b1001 goes to 3, then back to 0.
    reset_a();
    cycle(4'b0001, 4'b0000);
    cycle(4'b0001, 4'b0000);
    cycle(4'b1000, 4'b0000);
    cycle(4'b1001, 4'b0000);
    check("t4_first_id", 32'(id_a), 32'd3);
    cycle(4'b1001, 4'b0000);
    cycle(4'b0001, 4'b0000);
    cycle(4'b1001, 4'b0000);
    check("t4_second_id", 32'(id_a), 32'd0);
    check("t4_second_en", 32'(en_a), 32'h1);

    // Asynchronous reset in the middle of ownership.
    reset_a();
    for (int i = 0; i < 3; i++) cycle(4'b0010, 4'b0000);
    check("t5_pre_en", 32'(en_a), 32'h2);
    #2;
    rst_n_a = 1'b0;
    ma = mdl_reset();
    #1;
    check("t5_async_en", 32'(en_a), 32'h0);
    check("t5_async_gv", 32'(gv_a), 32'd0);
    cycle(4'b0011, 4'b0000);
    rst_n_a = 1'b1;
    cycle(4'b0011, 4'b0000);
    check("t5_regrant_id", 32'(id_a), 32'd0);
    check("t5_regrant_en", 32'(en_a), 32'h1);
    cycle(4'b0000, 4'b0000);
    cycle(4'b0000, 4'b0000);

    // Three-cycle turnaround, 4-cycle cap, lone requester re-granted repeatedly.
    rst_n_b = 1'b1;
    for (int k = 1; k <= 21; k++) begin
      cycle(4'b0000, 4'b0001);
      check($sformatf("t6_en_k%0d", k), 32'(en_b), (((k - 1) % 7) < 4) ? 32'h1 : 32'h0);
      check($sformatf("t6_turn_k%0d", k), 32'(turn_b), (((k - 1) % 7) >= 4) ? 32'd1 : 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
